// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and widths for the unified memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef enum logic {
    ARB_BOOT = 1'b0,
    ARB_RUN  = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the arbiter; slave = arbiter, master = CPU/DMA/memory environment.
interface mem_port_arbiter_if;
  import mem_arb_pkg::*;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_hold;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_done;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              mem_wr_ena;
  logic              mem_rd_ena;
  logic [DATA_W-1:0] mem_rd_data;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_hold,
    input  dma_req, dma_we, dma_addr, dma_wdata, dma_done,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_addr, mem_wr_data, mem_wr_ena, mem_rd_ena,
    input  mem_rd_data
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_hold,
    output dma_req, dma_we, dma_addr, dma_wdata, dma_done,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_addr, mem_wr_data, mem_wr_ena, mem_rd_ena,
    output mem_rd_data
  );

endinterface

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating count of consecutive denied DMA cycles; limit_hit hands DMA the next contended cycle.
module arb_starve_counter #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic rstb,
  input  logic clr,
  input  logic inc,
  output logic limit_hit
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && (cnt_q != LIMIT))
      cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign limit_hit = (cnt_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Unified memory port arbiter: BOOT phase grants only the loader, RUN phase is CPU-priority with DMA anti-starvation.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter bit          BOOT_EN      = 1'b1
) (
  input  logic               clk,
  input  logic               rstb,
  mem_port_arbiter_if.slave  bus
);

  localparam arb_state_e RST_STATE = BOOT_EN ? ARB_BOOT : ARB_RUN;

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              rd_pend_q, rd_pend_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;

  logic cpu_gnt, dma_gnt;
  logic limit_hit;
  logic cpu_ret, dma_ret;

  arb_starve_counter #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk       (clk),
    .rstb      (rstb),
    .clr       (dma_gnt || !bus.dma_req),
    .inc       ((state_q == ARB_RUN) && bus.dma_req && !dma_gnt),
    .limit_hit (limit_hit)
  );

  // Grants are gated by rstb so nothing reaches memory while reset is held.
  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (rstb) begin
      if (state_q == ARB_BOOT) begin
        dma_gnt = bus.dma_req;
      end else if (bus.cpu_req && bus.dma_req) begin
        dma_gnt = limit_hit;
        cpu_gnt = !limit_hit;
      end else begin
        cpu_gnt = bus.cpu_req;
        dma_gnt = bus.dma_req;
      end
    end
  end

  always_comb begin
    bus.mem_addr    = '0;
    bus.mem_wr_data = '0;
    bus.mem_wr_ena  = 1'b0;
    bus.mem_rd_ena  = 1'b0;
    if (cpu_gnt) begin
      bus.mem_addr    = bus.cpu_addr;
      bus.mem_wr_data = bus.cpu_wdata;
      bus.mem_wr_ena  = bus.cpu_we;
      bus.mem_rd_ena  = !bus.cpu_we;
    end else if (dma_gnt) begin
      bus.mem_addr    = bus.dma_addr;
      bus.mem_wr_data = bus.dma_wdata;
      bus.mem_wr_ena  = bus.dma_we;
      bus.mem_rd_ena  = !bus.dma_we;
    end
  end

  assign cpu_ret = rd_pend_q && (owner_q == OWN_CPU);
  assign dma_ret = rd_pend_q && (owner_q == OWN_DMA);

  always_comb begin
    state_d = state_q;
    if ((state_q == ARB_BOOT) && bus.dma_done)
      state_d = ARB_RUN;
    cpu_hold_d = (state_d == ARB_BOOT);

    rd_pend_d = bus.mem_rd_ena;
    owner_d   = owner_q;
    if (bus.mem_rd_ena)
      owner_d = dma_gnt ? OWN_DMA : OWN_CPU;

    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    if (cpu_ret) cpu_rdata_d = bus.mem_rd_data;
    if (dma_ret) dma_rdata_d = bus.mem_rd_data;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= RST_STATE;
      cpu_hold_q  <= BOOT_EN;
      owner_q     <= OWN_CPU;
      rd_pend_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cpu_hold_q  <= cpu_hold_d;
      owner_q     <= owner_d;
      rd_pend_q   <= rd_pend_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  // Memory data arrives in the return cycle, so rdata passes it straight through then holds it.
  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.dma_gnt    = dma_gnt;
  assign bus.cpu_hold   = cpu_hold_q;
  assign bus.cpu_rvalid = cpu_ret;
  assign bus.dma_rvalid = dma_ret;
  assign bus.cpu_rdata  = cpu_ret ? bus.mem_rd_data : cpu_rdata_q;
  assign bus.dma_rdata  = dma_ret ? bus.mem_rd_data : dma_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: u_a boots with STARVE_LIMIT=3, u_b starts in RUN with defaults.
module tb_mem_port_arbiter;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rstb;
  int   cyc_n = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  exp_t q_cpu_a[$];
  exp_t q_dma_a[$];
  exp_t q_cpu_b[$];

  mem_port_arbiter_if a ();
  mem_port_arbiter_if b ();

  mem_port_arbiter #(.STARVE_LIMIT(3), .BOOT_EN(1'b1)) u_a (
    .clk (clk), .rstb (rstb), .bus (a.slave)
  );
  mem_port_arbiter #(.STARVE_LIMIT(8), .BOOT_EN(1'b0)) u_b (
    .clk (clk), .rstb (rstb), .bus (b.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Memory models: unwritten words read back as C0DE_00xx.
  logic [31:0] mem_a [64];
  bit   [63:0] wr_a;
  logic [31:0] mem_b [64];
  bit   [63:0] wr_b;

  always @(posedge clk) begin
    if (a.mem_wr_ena) begin
      mem_a[a.mem_addr[7:2]] <= a.mem_wr_data;
      wr_a[a.mem_addr[7:2]]  <= 1'b1;
    end
    if (a.mem_rd_ena)
      a.mem_rd_data <= wr_a[a.mem_addr[7:2]] ? mem_a[a.mem_addr[7:2]]
                                             : (32'hC0DE_0000 | {24'h0, a.mem_addr[7:0]});
    if (b.mem_wr_ena) begin
      mem_b[b.mem_addr[7:2]] <= b.mem_wr_data;
      wr_b[b.mem_addr[7:2]]  <= 1'b1;
    end
    if (b.mem_rd_ena)
      b.mem_rd_data <= wr_b[b.mem_addr[7:2]] ? mem_b[b.mem_addr[7:2]]
                                             : (32'hC0DE_0000 | {24'h0, b.mem_addr[7:0]});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (a.cpu_rvalid) begin
      if (q_cpu_a.size() == 0) chk("a_cpu_rv_spurious", 1, 0);
      else begin
        e = q_cpu_a.pop_front();
        chk("a_cpu_rdata", a.cpu_rdata, e.data);
        chk("a_cpu_rv_cycle", cyc_n, e.due);
      end
    end else if (q_cpu_a.size() > 0 && q_cpu_a[0].due <= cyc_n) begin
      chk("a_cpu_rv_missing", 0, 1);
      void'(q_cpu_a.pop_front());
    end
    if (a.dma_rvalid) begin
      if (q_dma_a.size() == 0) chk("a_dma_rv_spurious", 1, 0);
      else begin
        e = q_dma_a.pop_front();
        chk("a_dma_rdata", a.dma_rdata, e.data);
        chk("a_dma_rv_cycle", cyc_n, e.due);
      end
    end else if (q_dma_a.size() > 0 && q_dma_a[0].due <= cyc_n) begin
      chk("a_dma_rv_missing", 0, 1);
      void'(q_dma_a.pop_front());
    end
    if (b.cpu_rvalid) begin
      if (q_cpu_b.size() == 0) chk("b_cpu_rv_spurious", 1, 0);
      else begin
        e = q_cpu_b.pop_front();
        chk("b_cpu_rdata", b.cpu_rdata, e.data);
        chk("b_cpu_rv_cycle", cyc_n, e.due);
      end
    end else if (q_cpu_b.size() > 0 && q_cpu_b[0].due <= cyc_n) begin
      chk("b_cpu_rv_missing", 0, 1);
      void'(q_cpu_b.pop_front());
    end
    if (b.dma_rvalid) chk("b_dma_rv_spurious", 1, 0);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle_all();
    a.cpu_req = 0; a.cpu_we = 0; a.cpu_addr = '0; a.cpu_wdata = '0;
    a.dma_req = 0; a.dma_we = 0; a.dma_addr = '0; a.dma_wdata = '0; a.dma_done = 0;
    b.cpu_req = 0; b.cpu_we = 0; b.cpu_addr = '0; b.cpu_wdata = '0;
    b.dma_req = 0; b.dma_we = 0; b.dma_addr = '0; b.dma_wdata = '0; b.dma_done = 0;
  endtask

  task automatic push(input bit to_cpu_a, input bit to_dma_a, input logic [31:0] d);
    exp_t e;
    e.data = d;
    e.due  = cyc_n + 1;
    if (to_cpu_a)      q_cpu_a.push_back(e);
    else if (to_dma_a) q_dma_a.push_back(e);
    else               q_cpu_b.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] pat;
    bit         exp_dma;

    idle_all();
    rstb = 1'b0;
    a.cpu_req = 1; a.cpu_addr = 32'h10;
    repeat (2) cyc();
    settle();
    chk("rst_cpu_hold", a.cpu_hold, 1);
    chk("rst_cpu_gnt", a.cpu_gnt, 0);
    chk("rst_dma_gnt", a.dma_gnt, 0);
    chk("rst_wr_ena", a.mem_wr_ena, 0);
    chk("rst_rd_ena", a.mem_rd_ena, 0);
    chk("rst_mem_addr", a.mem_addr, 0);
    chk("rst_cpu_rvalid", a.cpu_rvalid, 0);
    chk("rst_cpu_rdata", a.cpu_rdata, 0);
    chk("rst_dma_rdata", a.dma_rdata, 0);
    chk("rst_b_cpu_hold", b.cpu_hold, 0);

    // BOOT: CPU held off, DMA write goes through.
    cyc();
    rstb = 1'b1;
    a.cpu_req = 1; a.cpu_we = 0; a.cpu_addr = 32'h10;
    a.dma_req = 1; a.dma_we = 1; a.dma_addr = 32'h10; a.dma_wdata = 32'hDEAD_BEEF;
    settle();
    chk("boot_cpu_gnt", a.cpu_gnt, 0);
    chk("boot_cpu_hold", a.cpu_hold, 1);
    chk("boot_dma_gnt", a.dma_gnt, 1);
    chk("boot_wr_ena", a.mem_wr_ena, 1);
    chk("boot_rd_ena", a.mem_rd_ena, 0);
    chk("boot_mem_addr", a.mem_addr, 32'h10);
    chk("boot_wr_data", a.mem_wr_data, 32'hDEAD_BEEF);

    cyc();
    a.dma_we = 0; a.dma_done = 1;
    push(0, 1, 32'hDEAD_BEEF);
    settle();
    chk("done_dma_gnt", a.dma_gnt, 1);
    chk("done_rd_ena", a.mem_rd_ena, 1);
    chk("done_cpu_gnt", a.cpu_gnt, 0);
    chk("done_cpu_hold", a.cpu_hold, 1);

    cyc();
    a.dma_req = 0; a.dma_done = 0;
    push(1, 0, 32'hDEAD_BEEF);
    settle();
    chk("run_cpu_hold", a.cpu_hold, 0);
    chk("run_cpu_gnt", a.cpu_gnt, 1);
    chk("run_rd_ena", a.mem_rd_ena, 1);
    chk("run_mem_addr", a.mem_addr, 32'h10);

    cyc();
    a.cpu_req = 0; a.dma_done = 1;
    settle();
    chk("dma_rdata_hold", a.dma_rdata, 32'hDEAD_BEEF);
    chk("dma_rvalid_low", a.dma_rvalid, 0);
    cyc();
    a.dma_done = 0;
    settle();
    chk("run_ignores_done", a.cpu_hold, 0);

    // Contended writes, limit 3: CPU, CPU, CPU, DMA, repeating.
    pat = 8'b1000_1000;
    for (int i = 0; i < 8; i++) begin
      cyc();
      a.cpu_req = 1; a.cpu_we = 1; a.cpu_addr = 32'h40; a.cpu_wdata = 32'h1111_0000 + i;
      a.dma_req = 1; a.dma_we = 1; a.dma_addr = 32'h44; a.dma_wdata = 32'h2222_0000 + i;
      settle();
      exp_dma = pat[i];
      chk($sformatf("starve_dma_gnt%0d", i), a.dma_gnt, exp_dma);
      chk($sformatf("starve_cpu_gnt%0d", i), a.cpu_gnt, !exp_dma);
      chk($sformatf("starve_addr%0d", i), a.mem_addr, exp_dma ? 32'h44 : 32'h40);
      chk($sformatf("starve_max%0d", i), u_a.u_starve.cnt_q > 8'd3, 0);
    end

    // Preload words 0x0/0x4/0x8 via DMA, then alternate reads.
    for (int k = 0; k < 3; k++) begin
      cyc();
      a.cpu_req = 0;
      a.dma_req = 1; a.dma_we = 1; a.dma_addr = 4 * k; a.dma_wdata = 32'hA0A0_0000 + 4 * k;
      settle();
      chk($sformatf("preload_gnt%0d", k), a.dma_gnt, 1);
    end
    cyc();
    a.dma_req = 0; a.cpu_req = 1; a.cpu_we = 0; a.cpu_addr = 32'h0;
    push(1, 0, 32'hA0A0_0000);
    settle();
    chk("alt0_cpu_gnt", a.cpu_gnt, 1);
    cyc();
    a.cpu_req = 0; a.dma_req = 1; a.dma_we = 0; a.dma_addr = 32'h4;
    push(0, 1, 32'hA0A0_0004);
    settle();
    chk("alt1_dma_gnt", a.dma_gnt, 1);
    cyc();
    a.dma_req = 0; a.cpu_req = 1; a.cpu_addr = 32'h8;
    push(1, 0, 32'hA0A0_0008);
    settle();
    chk("alt2_cpu_gnt", a.cpu_gnt, 1);
    cyc();
    a.cpu_req = 0;
    settle();
    cyc();
    settle();

    // Reset lands before the return edge of a CPU read.
    cyc();
    a.cpu_req = 1; a.cpu_we = 0; a.cpu_addr = 32'h0;
    settle();
    chk("prerst_cpu_gnt", a.cpu_gnt, 1);
    #1 rstb = 1'b0;
    cyc();
    settle();
    chk("inrst_cpu_rvalid", a.cpu_rvalid, 0);
    chk("inrst_cpu_gnt", a.cpu_gnt, 0);
    chk("inrst_rd_ena", a.mem_rd_ena, 0);
    chk("inrst_mem_addr", a.mem_addr, 0);
    chk("inrst_cpu_hold", a.cpu_hold, 1);

    cyc();
    rstb = 1'b1;
    b.cpu_req = 1; b.cpu_we = 0; b.cpu_addr = 32'h20;
    push(0, 0, 32'hC0DE_0020);
    settle();
    chk("postrst_cpu_rvalid", a.cpu_rvalid, 0);
    chk("postrst_cpu_hold", a.cpu_hold, 1);
    chk("postrst_cpu_gnt", a.cpu_gnt, 0);
    chk("b_cpu_gnt", b.cpu_gnt, 1);
    chk("b_rd_ena", b.mem_rd_ena, 1);
    chk("b_cpu_hold0", b.cpu_hold, 0);
    cyc();
    idle_all();
    settle();
    chk("postrst_cpu_rvalid2", a.cpu_rvalid, 0);
    chk("b_cpu_hold1", b.cpu_hold, 0);
    cyc();
    settle();

    chk("q_cpu_a_empty", q_cpu_a.size(), 0);
    chk("q_dma_a_empty", q_dma_a.size(), 0);
    chk("q_cpu_b_empty", q_cpu_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single unified memory port between the multicycle CPU core and a program loader/DMA requester. It holds the CPU off after reset while the loader fills memory (boot phase). It then arbitrates per cycle with CPU priority, bounded by a DMA starvation limit. Read data returns one cycle after a granted read and is steered to the requester that issued it.

## Interface
- STARVE_LIMIT, default 8: consecutive denied DMA request cycles after which DMA wins the next contended cycle; legal range 1..255.
- BOOT_EN, default 1: 1 = start in BOOT phase; 0 = start directly in RUN.
- clk  input  1  clock, all state on rising edge.
- rstb  input  1  reset, asynchronous, active-low.
- cpu_req  input  1  CPU access request this cycle.
- cpu_we  input  1  CPU write (1) / read (0).
- cpu_addr  input  32  CPU byte address.
- cpu_wdata  input  32  CPU write data.
- cpu_gnt  output  1  CPU request accepted this cycle (combinational).
- cpu_rvalid  output  1  cpu_rdata valid (registered).
- cpu_rdata  output  32  CPU read data.
- cpu_hold  output  1  registered; 1 freezes the CPU (BOOT phase).
- dma_req, dma_we, dma_addr[31:0], dma_wdata[31:0]: inputs, same meaning as CPU side.
- dma_done  input  1  one-cycle pulse: loader finished boot image.
- dma_gnt  output  1  DMA request accepted this cycle (combinational).
- dma_rvalid  output  1  dma_rdata valid (registered).
- dma_rdata  output  32  DMA read data.
- mem_addr  output  32  memory address, muxed from granted requester, 0 when idle.
- mem_wr_data  output  32  memory write data, 0 when idle.
- mem_wr_ena  output  1  write strobe.
- mem_rd_ena  output  1  read strobe.
- mem_rd_data  input  32  synchronous read data, valid the cycle after mem_rd_ena.

## Operation
- States: BOOT, RUN. Reset enters BOOT if BOOT_EN=1, else RUN.
- BOOT: only DMA is granted (dma_gnt = dma_req); cpu_gnt = 0; cpu_hold = 1. dma_done moves to RUN next cycle. A DMA access granted in the dma_done cycle completes normally.
- RUN: cpu_hold = 0. If only one requester is active, it is granted. If both are active, CPU wins unless starve_cnt == STARVE_LIMIT, in which case DMA wins. dma_done is ignored in RUN; there is no return to BOOT except via reset.
- starve_cnt (8 bit): increments each RUN cycle with dma_req=1 and dma_gnt=0, saturating at STARVE_LIMIT. It clears on any dma_gnt or when dma_req=0.
- At most one grant per cycle. A grant with we=1 drives mem_wr_ena; we=0 drives mem_rd_ena.
- Owner register captures the granted requester on every read grant. Next cycle, that side's rvalid=1 and rdata=mem_rd_data. The other side's rdata holds its last value.
- Requests are not queued. A requester denied in a cycle keeps req asserted; the arbiter keeps no memory of it beyond starve_cnt.

## Timing
- Grant and memory strobes are combinational from req in the same cycle. Read latency is 1 cycle (grant cycle N, rvalid in N+1). Back-to-back reads from alternating requesters each return in their own N+1.
- Reset values: state = BOOT (or RUN), cpu_hold = BOOT_EN, cpu_rvalid = dma_rvalid = 0, cpu_rdata = dma_rdata = 0, starve_cnt = 0, owner = CPU.
- While rstb = 0, all gnt/strobes are 0 and mem_addr/mem_wr_data are 0.
- Reset asserted mid-read: the pending rvalid is dropped and does not appear after reset release.
- cpu_hold changes on the clock edge after dma_done; the first CPU grant is possible in the cycle cpu_hold falls.

## Structure
- Package mem_arb_pkg: state enum (ARB_BOOT, ARB_RUN), owner encoding (OWN_CPU=0, OWN_DMA=1), address and data width constants (32).
- Sub-module arb_starve_counter: saturating counter with clear, increment and limit-reached output; parameterised by STARVE_LIMIT.
- Top module: FSM, grant logic, memory mux, owner and read-return registers.

## Test plan
- Reset with BOOT_EN=1: cpu_hold=1, all outputs 0. cpu_req with addr 0x10 gets no grant. DMA write 0xDEADBEEF to 0x10 → dma_gnt=1, mem_wr_ena=1, mem_addr=0x10.
- dma_done pulse during a DMA read of 0x10 → dma_rvalid=1 with 0xDEADBEEF next cycle, cpu_hold=0 that same cycle, then a CPU read of 0x10 granted and returning 0xDEADBEEF one cycle later.
- RUN, both requesting continuously, STARVE_LIMIT=3 → CPU granted 3 cycles, DMA the 4th, pattern repeats. starve_cnt is never above 3.
- Alternating reads CPU@0x0, DMA@0x4, CPU@0x8 → each rvalid pulses only on the issuing side, one cycle after its grant, with the correct word.
- rstb pulsed low in the cycle after a CPU read grant → cpu_rvalid stays 0, state returns to BOOT, cpu_hold=1.
- BOOT_EN=0: first cycle after reset, a CPU read of 0x20 is granted immediately and cpu_hold=0 throughout.
